// File: rtl/rtx_fb_writer.sv
// rtx_fb_writer: framebuffer write stage for the rtx tracer.
//
// Each traced pixel arriving on i_ray_done is converted from (column, row) to a
// linear framebuffer address, registered for one cycle, then queued in a small
// FIFO that drains into the memory port through a valid/ready handshake. Writes
// to the last address of the frame raise a one-cycle o_frame_done pulse and
// bump o_frame_count.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_rtx_pixel    RGB565 colour of the traced pixel
//   i_pixel_h      pixel column
//   i_pixel_v      pixel row
//   i_ray_done     one-cycle strobe qualifying the three inputs above
//   o_fb_addr      framebuffer write address (FIFO head, 0 when empty)
//   o_fb_data      framebuffer write data (FIFO head, 0 when empty)
//   o_fb_we        write request, high whenever the FIFO holds an entry
//   i_fb_ready     memory accepts the current write this cycle
//   o_frame_done   one-cycle pulse after the last-address write is accepted
//   o_frame_count  completed-frame counter, wraps 255 -> 0
//   o_overflow     sticky: a pixel was dropped because the FIFO was full
//   o_fifo_level   current FIFO occupancy, 0..FIFO_DEPTH
module rtx_fb_writer #(
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 720,
  parameter int unsigned FIFO_DEPTH = 8,   // power of 2, >= 2
  parameter int unsigned ADDR_W     = 20   // 2**ADDR_W >= WIDTH*HEIGHT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [15:0]                   i_rtx_pixel,
  input  logic [10:0]                   i_pixel_h,
  input  logic [9:0]                    i_pixel_v,
  input  logic                          i_ray_done,
  output logic [ADDR_W-1:0]             o_fb_addr,
  output logic [15:0]                   o_fb_data,
  output logic                          o_fb_we,
  input  logic                          i_fb_ready,
  output logic                          o_frame_done,
  output logic [7:0]                    o_frame_count,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);

  // Stage 1: coordinate check and address computation
  logic [31:0]       w_addr_full;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_range;

  // Full-width multiply-add; truncation happens only on the final sum.
  assign w_addr_full = 32'(i_pixel_v) * 32'(WIDTH) + 32'(i_pixel_h);
  assign w_addr      = ADDR_W'(w_addr_full);
  assign w_in_range  = (32'(i_pixel_h) < WIDTH) && (32'(i_pixel_v) < HEIGHT);

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [15:0]       r_s1_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= i_ray_done && w_in_range;
      if (i_ray_done && w_in_range) begin
        r_s1_addr <= w_addr;
        r_s1_data <= i_rtx_pixel;
      end
    end
  end

  // Stage 2: FIFO
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [15:0]       r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [ADDR_W-1:0] w_head_addr;
  logic [15:0]       w_head_data;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == FULL_LEVEL);
  assign w_pop       = !w_empty && i_fb_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push      = r_s1_valid && (!w_full || w_pop);
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= r_s1_addr;
      r_mem_data[r_wr_ptr] <= r_s1_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (r_s1_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame tracking
  logic       r_frame_done;
  logic [7:0] r_frame_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_pop && (w_head_addr == LAST_ADDR);
      if (w_pop && (w_head_addr == LAST_ADDR)) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Outputs
  assign o_fb_we       = !w_empty;
  assign o_fb_addr     = w_empty ? '0 : w_head_addr;
  assign o_fb_data     = w_empty ? '0 : w_head_data;
  assign o_frame_done  = r_frame_done;
  assign o_frame_count = r_frame_count;
  assign o_overflow    = r_overflow;
  assign o_fifo_level  = r_level;

endmodule

// File: tb/tb_rtx_fb_writer.sv
// Self-checking bench for rtx_fb_writer: a table of single-pixel vectors,
// hand-written corner sequences, and a randomized phase, all compared every
// cycle against a queue-based reference model.
module tb_rtx_fb_writer;

  localparam int W     = 1280;
  localparam int H     = 720;
  localparam int DEPTH = 8;
  localparam int LAST  = W * H - 1;

  logic        clk;
  logic        rst;
  logic [15:0] rtx_pixel;
  logic [10:0] pixel_h;
  logic [9:0]  pixel_v;
  logic        ray_done;
  logic [19:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        overflow;
  logic [3:0]  fifo_level;

  rtx_fb_writer #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (20)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rtx_pixel  (rtx_pixel),
    .i_pixel_h    (pixel_h),
    .i_pixel_v    (pixel_v),
    .i_ray_done   (ray_done),
    .o_fb_addr    (fb_addr),
    .o_fb_data    (fb_data),
    .o_fb_we      (fb_we),
    .i_fb_ready   (fb_ready),
    .o_frame_done (frame_done),
    .o_frame_count(frame_count),
    .o_overflow   (overflow),
    .o_fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a delay slot for the address stage and a bounded queue.
  typedef struct {
    int          addr;
    logic [15:0] data;
  } ent_t;

  ent_t mq[$];
  ent_t m_s1;
  bit   m_s1v;
  bit   m_ovf;
  bit   m_fd;
  int   m_cnt;

  task automatic model_reset();
    mq.delete();
    m_s1v = 0;
    m_ovf = 0;
    m_fd  = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input bit rd, input int h, input int v, input logic [15:0] pix,
                            input bit rdy);
    ent_t e;
    m_fd = 0;
    if (rdy && mq.size() > 0) begin
      e = mq.pop_front();
      if (e.addr == LAST) begin
        m_fd  = 1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    if (m_s1v) begin
      if (mq.size() < DEPTH) mq.push_back(m_s1);
      else m_ovf = 1;
    end
    m_s1v = rd && (h < W) && (v < H);
    m_s1.addr = v * W + h;
    m_s1.data = pix;
  endtask

  task automatic compare_model();
    check("fb_we", fb_we, mq.size() != 0);
    check("fb_addr", fb_addr, (mq.size() != 0) ? mq[0].addr : 0);
    check("fb_data", fb_data, (mq.size() != 0) ? mq[0].data : 0);
    check("fifo_level", fifo_level, mq.size());
    check("overflow", overflow, m_ovf);
    check("frame_done", frame_done, m_fd);
    check("frame_count", frame_count, m_cnt);
  endtask

  // One clock: drive inputs, let the edge happen, then sample 1 time unit later.
  task automatic cycle(input bit rd, input int h, input int v, input logic [15:0] pix,
                       input bit rdy);
    ray_done  = rd;
    pixel_h   = h[10:0];
    pixel_v   = v[9:0];
    rtx_pixel = pix;
    fb_ready  = rdy;
    @(posedge clk);
    cyc++;
    model_step(rd, h, v, pix, rdy);
    #1;
    ray_done = 1'b0;
    compare_model();
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 16'h0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int          h;
    int          v;
    logic [15:0] pix;
    bit          valid;
    int          addr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nwr;
    vecs[0] = '{3,    2,    16'hF800, 1, 2563};
    vecs[1] = '{0,    0,    16'h07E0, 1, 0};
    vecs[2] = '{1279, 0,    16'h001F, 1, 1279};
    vecs[3] = '{0,    1,    16'hFFFF, 1, 1280};
    vecs[4] = '{640,  360,  16'h1234, 1, 461440};
    vecs[5] = '{100,  500,  16'hABCD, 1, 640100};
    vecs[6] = '{1279, 719,  16'h5A5A, 1, 921599};
    vecs[7] = '{1280, 0,    16'h1111, 0, 0};
    vecs[8] = '{0,    720,  16'h2222, 0, 0};
    vecs[9] = '{2047, 1023, 16'h3333, 0, 0};

    rst = 1'b1;
    ray_done = 1'b0;
    pixel_h = '0;
    pixel_v = '0;
    rtx_pixel = '0;
    fb_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_count", frame_count, 0);
    rst = 1'b0;

    // Table: one pixel at a time, fb_ready low until the write is visible.
    for (int i = 0; i < 10; i++) begin
      cycle(1, vecs[i].h, vecs[i].v, vecs[i].pix, 0);
      idle(0);
      check("vec_we", fb_we, vecs[i].valid);
      check("vec_addr", fb_addr, vecs[i].addr);
      check("vec_data", fb_data, vecs[i].valid ? vecs[i].pix : 16'h0);
      idle(1);
      check("vec_we_drop", fb_we, 0);
      check("vec_level", fifo_level, 0);
      check("vec_frame_done", frame_done, vecs[i].valid && (vecs[i].addr == LAST));
      check("vec_overflow", overflow, 0);
    end

    // Single pixel with fb_ready held high: visible exactly 2 cycles after strobe.
    do_reset();
    cycle(1, 3, 2, 16'hF800, 1);
    check("sp_we_n1", fb_we, 0);
    idle(1);
    check("sp_we", fb_we, 1);
    check("sp_addr", fb_addr, 2563);
    check("sp_data", fb_data, 16'hF800);
    idle(1);
    check("sp_we_drop", fb_we, 0);
    check("sp_level", fifo_level, 0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, i, 0, 16'(16'h100 + i), 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      check("bp_hold_addr", fb_addr, 0);
      check("bp_hold_we", fb_we, 1);
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_write_we", fb_we, 1);
      check("bp_write_addr", fb_addr, i);
      idle(1);
    end
    check("bp_empty", fb_we, 0);
    check("bp_overflow", overflow, 0);

    // Overflow: 10 back-to-back strobes into a stalled FIFO.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, i, 0, 16'(16'h200 + i), 0);
    idle(0);
    idle(0);
    check("ovf_level", fifo_level, 8);
    check("ovf_flag", overflow, 1);
    nwr = 0;
    for (int i = 0; i < 12; i++) begin
      if (fb_we) begin
        check("ovf_order", fb_addr, nwr);
        nwr++;
      end
      idle(1);
    end
    check("ovf_writes", nwr, 8);
    check("ovf_sticky", overflow, 1);

    // Out-of-range coordinates
    do_reset();
    cycle(1, 1280, 0, 16'hAAAA, 1);
    cycle(1, 0, 720, 16'hBBBB, 1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("oor_we", fb_we, 0);
      check("oor_level", fifo_level, 0);
      check("oor_overflow", overflow, 0);
    end

    // Frame done and counter wrap
    do_reset();
    for (int f = 0; f < 256; f++) begin
      cycle(1, 1279, 719, 16'(f), 1);
      idle(1);
      if (f == 0) begin
        check("fd_addr", fb_addr, 921599);
        check("fd_pre", frame_done, 0);
      end
      idle(1);
      if (f == 0) begin
        check("fd_pulse", frame_done, 1);
        check("fd_count1", frame_count, 1);
        idle(1);
        check("fd_pulse_end", frame_done, 0);
      end
    end
    check("fd_wrap", frame_count, 0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 10 + i, 3, 16'(16'h300 + i), 0);
    idle(0);
    check("rm_level5", fifo_level, 5);
    rst = 1'b1;
    #1;
    check("rm_we", fb_we, 0);
    check("rm_level", fifo_level, 0);
    check("rm_overflow", overflow, 0);
    check("rm_addr", fb_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("rm_no_stale", fb_we, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int h;
      int v;
      bit rd;
      bit rdy;
      rd  = ($urandom_range(0, 99) < 55);
      rdy = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 19) == 0) begin
        h = 1279;
        v = 719;
      end else begin
        h = $urandom_range(0, 1300);
        v = $urandom_range(0, 730);
      end
      cycle(rd, h, v, 16'($urandom), rdy);
    end
    for (int i = 0; i < 12; i++) idle(1);
    check("rand_drained", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtx_fb_writer.md
# rtx_fb_writer

Downstream stage of `rtx`. It takes each traced pixel (`rtx_pixel`, `pixel_h`, `pixel_v`, `ray_done`) and converts its coordinates to a linear framebuffer address. Pixels are held in a small FIFO and written into the framebuffer memory port with a valid/ready handshake. The block also detects frame completion and counts frames, so display logic knows when a full image has landed in memory.

## Interface
- `WIDTH`, default 1280: frame width in pixels.
- `HEIGHT`, default 720: frame height in pixels.
- `FIFO_DEPTH`, default 8: pixel FIFO entries; must be a power of 2, at least 2.
- `ADDR_W`, default 20: framebuffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rtx_pixel`  in  16  RGB565 pixel colour from `rtx`.
- `pixel_h`  in  11  pixel column.
- `pixel_v`  in  10  pixel row.
- `ray_done`  in  1  single-cycle strobe; the three inputs above are valid in this cycle.
- `fb_addr`  out  ADDR_W  framebuffer write address.
- `fb_data`  out  16  framebuffer write data.
- `fb_we`  out  1  write request (valid).
- `fb_ready`  in  1  memory accepts the write this cycle.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is written.
- `frame_count`  out  8  completed-frame counter.
- `overflow`  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
**Stage 1: address.**
- On `ray_done` with `pixel_h < WIDTH` and `pixel_v < HEIGHT`, register `{addr = pixel_v*WIDTH + pixel_h, rtx_pixel}` and set `s1_valid`.
- Compute `addr` at full width; truncate to ADDR_W only after the add.
- An out-of-range coordinate is silently dropped. It does not set `overflow`.

**Stage 2: FIFO push.**
- When `s1_valid` is set, push the stage-1 entry into the FIFO.
- The push is accepted if the FIFO is not full, or if a pop happens in the same cycle. In the simultaneous push+pop case at full, the level is unchanged.
- Otherwise the entry is discarded and `overflow` is set. `overflow` stays set until `rst`.

**Output.**
- `fb_we = (fifo_level != 0)`.
- `fb_addr`/`fb_data` show the FIFO head while `fb_we` = 1, and are forced to 0 when the FIFO is empty.
- A write completes (pop) on a cycle with `fb_we && fb_ready`.
- While `fb_we` = 1 and `fb_ready` = 0, `fb_addr`/`fb_data` hold stable.
- `fb_ready` is ignored when the FIFO is empty.

**Frame tracking.**
- When a popped entry has `addr == WIDTH*HEIGHT-1`, `frame_done` pulses in the next cycle.
- `frame_count` increments on that same edge and wraps 255→0.
- Pixel order is not checked. Only the last-address write marks a frame.

**Pointers.**
- `rd_ptr`/`wr_ptr` are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- `fifo_level` runs from 0 to FIFO_DEPTH inclusive.

## Timing
- **Reset:** `rst` asserted clears all state asynchronously in the same cycle. This covers `s1_valid`, pointers, `fifo_level`, `overflow`, `frame_count` and `frame_done`; `fb_we`, `fb_addr` and `fb_data` go to 0. FIFO contents are discarded, and no write is issued during reset.
- **Reset release:** the block accepts `ray_done` from the first rising edge with `rst` = 0.
- **Latency:** `ray_done` in cycle N gives `s1_valid` in N+1. With the FIFO empty, `fb_we` = 1 with the matching addr/data in N+2.
- **Throughput:** one pixel per cycle sustained, given `fb_ready` held at 1.
- **Ordering:** writes leave in exactly the order of the accepted `ray_done` strobes.
- **`frame_done`:** high for exactly one cycle, in the cycle after the accepting edge of the last-address write.

## Test plan
- **Single pixel:** reset, then `ray_done` with h=3, v=2, pixel 0xF800, `fb_ready`=1. Required: `fb_we`=1, `fb_addr`=2563, `fb_data`=0xF800 exactly 2 cycles after the strobe. `fb_we` drops the following cycle and `fifo_level` returns to 0.
- **Backpressure:** push 3 pixels at addresses 0, 1, 2 with `fb_ready`=0 for 5 cycles, then `fb_ready`=1. Required: `fb_addr` holds 0 while stalled, then writes 0, 1, 2 on consecutive cycles, and `overflow` stays 0.
- **Overflow:** `fb_ready`=0, then 10 back-to-back strobes. Required: `fifo_level` saturates at 8 and `overflow`=1. After releasing `fb_ready`, exactly 8 writes occur, for the first 8 pixels in order.
- **Out-of-range:** h=1280 (v=0), then v=720 (h=0). Required: no write occurs, `fifo_level` stays 0 and `overflow` stays 0.
- **Frame done:** write h=1279, v=719 and accept it. Required: `fb_addr`=921599, and `frame_done` pulses for 1 cycle. `frame_count` goes 0→1; after 256 such frames it reads 0.
- **Reset mid-operation:** fill the FIFO with 5 entries under `fb_ready`=0, then assert `rst` for 1 cycle. Required: `fb_we`, `fifo_level` and `overflow` read 0 immediately, and after release `fb_ready`=1 produces no stale writes.
